// File: rtl/aud_pkg.sv
// Shared audio definitions used by the player and the recorder.
package aud_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    PAUSED
  } state_e;

  typedef enum logic {
    LEFT,
    RIGHT
  } chan_e;

endpackage

// File: rtl/aud_lrc_edge.sv
// Registers the codec LR clock and flags its rising and falling edges.
module aud_lrc_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_lrc,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic lrc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q <= 1'b0;
    end else begin
      lrc_q <= i_lrc;
    end
  end

  assign o_rise_c = ~lrc_q & i_lrc;
  assign o_fall_c = lrc_q & ~i_lrc;

endmodule

// File: rtl/aud_player.sv
// Streams 16-bit mono SRAM words onto the codec DAC line, MSB first, once per
// channel slot of every LRC frame, advancing one word per frame up to end_addr.
module aud_player
  import aud_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_dac_data,
  output logic              o_playing,
  output logic              o_done
);

  state_e            state_q, state_d;
  chan_e             chan_q, chan_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dac_q, dac_d;
  logic              done_q, done_d;
  logic              play_q, play_d;

  logic              rise_c, fall_c;
  logic              slot_edge_c, slot_end_c;
  logic [IDX_W-1:0]  bit_idx_c;

  aud_lrc_edge u_lrc_edge (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_lrc    (i_lrc),
    .o_rise_c (rise_c),
    .o_fall_c (fall_c)
  );

  // Left slot opens on the falling LRC edge, right slot on the rising one.
  assign slot_edge_c = (chan_q == LEFT) ? fall_c : rise_c;
  // A slot closes after 16 bits, or early if the LRC clock toggles first.
  assign slot_end_c  = (cnt_q == CNT_W'(DATA_W)) || rise_c || fall_c;
  assign bit_idx_c   = IDX_W'(DATA_W - 1) - IDX_W'(cnt_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      chan_q  <= LEFT;
      cnt_q   <= '0;
      word_q  <= '0;
      end_q   <= '0;
      addr_q  <= '0;
      dac_q   <= 1'b0;
      done_q  <= 1'b0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      end_q   <= end_d;
      addr_q  <= addr_d;
      dac_q   <= dac_d;
      done_q  <= done_d;
      play_q  <= play_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    end_d   = end_q;
    addr_d  = addr_q;
    dac_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start && !i_pause && !i_stop) begin
          addr_d  = '0;
          end_d   = i_end_addr;
          chan_d  = LEFT;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (i_stop) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (i_pause) begin
          cnt_d   = '0;
          state_d = PAUSED;
        end else if (slot_edge_c) begin
          // Right slot replays the word captured for the left slot.
          if (chan_q == LEFT) begin
            word_d = i_sram_data;
            dac_d  = i_sram_data[DATA_W-1];
          end else begin
            dac_d  = word_q[DATA_W-1];
          end
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (i_stop) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (i_pause) begin
          cnt_d   = '0;
          state_d = PAUSED;
        end else if (slot_end_c) begin
          cnt_d = '0;
          if (chan_q == LEFT) begin
            chan_d  = RIGHT;
            state_d = WAIT;
          end else if (addr_q == end_q) begin
            done_d  = 1'b1;
            addr_d  = '0;
            chan_d  = LEFT;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            chan_d  = LEFT;
            state_d = WAIT;
          end
        end else begin
          dac_d = word_q[bit_idx_c];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PAUSED: begin
        if (i_stop) begin
          addr_d  = '0;
          state_d = IDLE;
        end else if (i_start && !i_pause) begin
          chan_d  = LEFT;
          state_d = WAIT;
        end
      end

      default: state_d = IDLE;
    endcase

    play_d = (state_d == WAIT) || (state_d == SHIFT);
  end

  assign o_address  = addr_q;
  assign o_dac_data = dac_q;
  assign o_playing  = play_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_aud_player.sv
// Directed self-checking bench for aud_player: frames, address walk, pause,
// command priority, async reset, address wrap and truncated slots.
module tb_aud_player;

  logic        clk;
  logic        rst_n;
  logic        i_lrc;
  logic        i_start;
  logic        i_pause;
  logic        i_stop;
  logic [19:0] i_end_addr;
  logic [15:0] i_sram_data;
  logic [19:0] o_address;
  logic        o_dac_data;
  logic        o_playing;
  logic        o_done;

  int          n_checks;
  int          n_pass;
  int          lrc_half;
  int          lrc_cnt;
  logic [15:0] word0;

  aud_player dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_lrc       (i_lrc),
    .i_start     (i_start),
    .i_pause     (i_pause),
    .i_stop      (i_stop),
    .i_end_addr  (i_end_addr),
    .i_sram_data (i_sram_data),
    .o_address   (o_address),
    .o_dac_data  (o_dac_data),
    .o_playing   (o_playing),
    .o_done      (o_done)
  );

  function automatic logic [15:0] word_of(input logic [19:0] a, input logic [15:0] w0);
    case (a)
      20'h00000: return w0;
      20'h00001: return 16'h2222;
      20'h00002: return 16'h3333;
      20'h00003: return 16'h4444;
      20'hFFFFE: return 16'h5AF0;
      20'hFFFFF: return 16'h0FF1;
      default:   return 16'h0000;
    endcase
  endfunction

  assign i_sram_data = word_of(o_address, word0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // LRC generator: half period in BCLK cycles, changes just after posedge.
  initial begin
    i_lrc   = 1'b0;
    lrc_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (lrc_cnt >= lrc_half - 1) begin
        lrc_cnt = 0;
        i_lrc   = ~i_lrc;
      end else begin
        lrc_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_edge(input logic lvl);
    logic prev;
    logic found;
    prev  = i_lrc;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (i_lrc == lvl && prev != lvl) found = 1'b1;
      prev = i_lrc;
    end
    chk("lrc_edge_seen", 32'(found), 32'(1));
  endtask

  task automatic pulse(input logic s, input logic p, input logic x);
    @(posedge clk);
    #1;
    i_start = s;
    i_pause = p;
    i_stop  = x;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic grab(input int n, output logic [15:0] v);
    v = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v = {v[14:0], o_dac_data};
    end
  endtask

  // Start mid-frame so the next falling edge is well clear of the pulse.
  task automatic start_play(input logic [19:0] ea);
    i_end_addr = ea;
    wait_edge(1'b1);
    pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic play_frame(input logic [15:0] w, input logic [19:0] cur,
                            input logic [19:0] nxt, input logic dn, input string tag);
    logic [15:0] got;
    wait_edge(1'b0);
    chk({tag, "_addr"}, 32'(o_address), 32'(cur));
    grab(16, got);
    chk({tag, "_left"}, 32'(got), 32'(w));
    @(negedge clk);
    chk({tag, "_lgap"}, 32'(o_dac_data), 32'(0));
    wait_edge(1'b1);
    grab(16, got);
    chk({tag, "_right"}, 32'(got), 32'(w));
    @(negedge clk);
    chk({tag, "_rgap"}, 32'(o_dac_data), 32'(0));
    chk({tag, "_done"}, 32'(o_done), 32'(dn));
    chk({tag, "_next"}, 32'(o_address), 32'(nxt));
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(o_done), 32'(0));
  endtask

  initial begin
    logic [15:0] got;
    int          bad;
    logic        seen;

    n_checks   = 0;
    n_pass     = 0;
    lrc_half   = 32;
    word0      = 16'hA5C3;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_pause    = 1'b0;
    i_stop     = 1'b0;
    i_end_addr = '0;

    #13;
    chk("rst_addr", 32'(o_address), 32'(0));
    chk("rst_dac", 32'(o_dac_data), 32'(0));
    chk("rst_playing", 32'(o_playing), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    #10;
    rst_n = 1'b1;

    // Basic frame, single word
    start_play(20'h0);
    @(negedge clk);
    chk("basic_playing", 32'(o_playing), 32'(1));
    play_frame(16'hA5C3, 20'h0, 20'h0, 1'b1, "basic");
    chk("basic_idle", 32'(o_playing), 32'(0));

    // Address walk 0..3
    word0 = 16'h1111;
    start_play(20'h3);
    play_frame(16'h1111, 20'h0, 20'h1, 1'b0, "walk0");
    play_frame(16'h2222, 20'h1, 20'h2, 1'b0, "walk1");
    play_frame(16'h3333, 20'h2, 20'h3, 1'b0, "walk2");
    play_frame(16'h4444, 20'h3, 20'h0, 1'b1, "walk3");
    chk("walk_idle", 32'(o_playing), 32'(0));

    // Pause during address 2 left slot, then resume
    start_play(20'h3);
    play_frame(16'h1111, 20'h0, 20'h1, 1'b0, "pz0");
    play_frame(16'h2222, 20'h1, 20'h2, 1'b0, "pz1");
    wait_edge(1'b0);
    grab(7, got);
    chk("pz_partial", 32'(got[6:0]), 32'(7'b0011001));
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("pz_dac", 32'(o_dac_data), 32'(0));
    chk("pz_playing", 32'(o_playing), 32'(0));
    chk("pz_addr", 32'(o_address), 32'(2));
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_dac_data !== 1'b0 || o_address !== 20'h2 || o_playing !== 1'b0) bad++;
    end
    chk("pz_hold", 32'(bad), 32'(0));
    start_play(20'h3);
    play_frame(16'h3333, 20'h2, 20'h3, 1'b0, "pz2");
    play_frame(16'h4444, 20'h3, 20'h0, 1'b1, "pz3");

    // Priority: all three commands mid-SHIFT
    start_play(20'h3);
    play_frame(16'h1111, 20'h0, 20'h1, 1'b0, "pri0");
    wait_edge(1'b0);
    grab(5, got);
    pulse(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("pri_playing", 32'(o_playing), 32'(0));
    chk("pri_addr", 32'(o_address), 32'(0));
    chk("pri_dac", 32'(o_dac_data), 32'(0));
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_playing !== 1'b0) bad++;
    end
    chk("pri_quiet", 32'(bad), 32'(0));
    pulse(1'b1, 1'b0, 1'b1);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_playing !== 1'b0 || o_dac_data !== 1'b0) bad++;
    end
    chk("pri_idle_startstop", 32'(bad), 32'(0));

    // Asynchronous reset mid-SHIFT
    start_play(20'h3);
    play_frame(16'h1111, 20'h0, 20'h1, 1'b0, "rs0");
    wait_edge(1'b0);
    grab(3, got);
    chk("rs_bit13", 32'(o_dac_data), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_addr", 32'(o_address), 32'(0));
    chk("rs_dac", 32'(o_dac_data), 32'(0));
    chk("rs_playing", 32'(o_playing), 32'(0));
    chk("rs_done", 32'(o_done), 32'(0));
    #3;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (o_playing !== 1'b0 || o_dac_data !== 1'b0 || o_address !== 20'h0) bad++;
    end
    chk("rs_stays_idle", 32'(bad), 32'(0));

    // Top of address space, end at the last address
    start_play(20'hFFFFF);
    force dut.addr_q = 20'hFFFFE;
    @(posedge clk);
    @(posedge clk);
    #1;
    release dut.addr_q;
    play_frame(16'h5AF0, 20'hFFFFE, 20'hFFFFF, 1'b0, "top0");
    play_frame(16'h0FF1, 20'hFFFFF, 20'h00000, 1'b1, "top1");

    // Increment wraps from the last address to 0
    start_play(20'h0);
    force dut.addr_q = 20'hFFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    release dut.addr_q;
    play_frame(16'h0FF1, 20'hFFFFF, 20'h00000, 1'b0, "wrap0");
    play_frame(16'h1111, 20'h00000, 20'h00000, 1'b1, "wrap1");

    // Short 10-BCLK slots truncate the word without lockup
    lrc_half = 10;
    word0    = 16'hA5C3;
    start_play(20'h0);
    wait_edge(1'b0);
    grab(10, got);
    chk("short_bits", 32'(got[9:0]), 32'(10'h297));
    @(negedge clk);
    chk("short_gap", 32'(o_dac_data), 32'(0));
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) seen = 1'b1;
    end
    chk("short_done", 32'(seen), 32'(1));
    @(negedge clk);
    chk("short_idle", 32'(o_playing), 32'(0));
    chk("short_addr", 32'(o_address), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
